// File: rtl/queue_fifo_ctrl.sv
// First-word fall-through FIFO with valid/ready on both sides.
// Emits net inc/dec strobes for a downstream occupancy counter.
module queue_fifo_ctrl #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     inc,
  output logic                     dec
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              push, pop;

  assign full      = (count_q == FULL_CNT);
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign in_ready  = !full & !flush & !reset;
  assign out_valid = !empty;
  assign out_data  = mem_q[rd_ptr_q];

  // A pop during flush or reset is dropped so the counter sees no strobe.
  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready & !flush & !reset;
  assign inc  = push & !pop;
  assign dec  = pop & !push;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      if (inc)
        count_d = count_q + (ADDR_W+1)'(1);
      else if (dec)
        count_d = count_q - (ADDR_W+1)'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

endmodule

// File: tb/tb_queue_fifo_ctrl.sv
// Scoreboard bench for queue_fifo_ctrl: directed traffic,
// monitor pops expected data on every accepted read.
module tb_queue_fifo_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [4:0]  count;
  logic        full, empty, inc, dec;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb [$];

  queue_fifo_ctrl #(.DATA_W(32), .DEPTH(16)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count), .full(full), .empty(empty), .inc(inc), .dec(dec)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted pop must match the oldest expected entry.
  always @(negedge clock) begin
    if (!reset && !flush && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected: got %0h expected none", out_data);
      end else begin
        chk("pop_data", out_data, sb.pop_front());
      end
    end
    if (!reset) chk("inc_dec_excl", 32'(inc & dec), 32'd0);
  end

  // One cycle of stimulus; inputs change 1 time unit after the rising edge.
  task automatic cyc(input logic iv, input logic [31:0] d, input logic ordy,
                     input logic fl, input logic e_rdy, input logic e_inc,
                     input logic e_dec);
    @(posedge clock);
    #1;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    @(negedge clock);
    chk("in_ready", 32'(in_ready), 32'(e_rdy));
    chk("inc", 32'(inc), 32'(e_inc));
    chk("dec", 32'(dec), 32'(e_dec));
    if (iv && e_rdy) sb.push_back(d);
  endtask

  task automatic idle_chk(input int n);
    cyc(1'b0, 32'd0, 1'b0, 1'b0, n != 16, 1'b0, 1'b0);
    chk("count", 32'(count), 32'(n));
    chk("empty", 32'(empty), 32'(n == 0));
    chk("full", 32'(full), 32'(n == 16));
    chk("out_valid", 32'(out_valid), 32'(n != 0));
  endtask

  task automatic fill(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++)
      cyc(1'b1, base + 32'(i), 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic drain(input int n, input logic was_full);
    for (int i = 0; i < n; i++)
      cyc(1'b0, 32'd0, 1'b1, 1'b0, !(was_full && i == 0), 1'b0, 1'b1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_inc", 32'(inc), 32'd0);
    chk("rst_dec", 32'(dec), 32'd0);

    // 1: single push, fall-through next cycle
    cyc(1'b1, 32'hA5A5_0001, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    idle_chk(1);
    chk("t1_out_data", out_data, 32'hA5A5_0001);
    drain(1, 1'b0);
    idle_chk(0);

    // 2: fill to full, 17th push refused
    fill(16, 32'h1000);
    cyc(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle_chk(16);
    chk("t2_head", out_data, 32'h1000);
    drain(16, 1'b1);
    idle_chk(0);

    // 3: fill, drain, refill 0..15 across pointer wrap
    fill(16, 32'h2000);
    drain(16, 1'b1);
    idle_chk(0);
    fill(16, 32'd0);
    idle_chk(16);
    drain(16, 1'b1);
    idle_chk(0);

    // 4: simultaneous push and pop at count=5
    fill(5, 32'h50);
    cyc(1'b1, 32'h55, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    idle_chk(5);
    drain(5, 1'b0);
    idle_chk(0);

    // 5: flush at count=9 with push and pop requested
    fill(9, 32'h70);
    cyc(1'b1, 32'h99, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t5_flush_out_valid", 32'(out_valid), 32'd1);
    sb.delete();
    idle_chk(0);
    cyc(1'b1, 32'h123, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    idle_chk(1);
    chk("t5_after_flush_data", out_data, 32'h123);
    drain(1, 1'b0);

    // 6: reset mid-stream at count=7
    fill(7, 32'h300);
    idle_chk(7);
    @(posedge clock);
    #1;
    reset = 1'b1;
    in_valid = 1'b1;
    in_data = 32'h777;
    out_ready = 1'b1;
    @(negedge clock);
    chk("t6_rst_in_ready", 32'(in_ready), 32'd0);
    chk("t6_rst_inc", 32'(inc), 32'd0);
    chk("t6_rst_dec", 32'(dec), 32'd0);
    sb.delete();
    @(posedge clock);
    #1;
    reset = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(negedge clock);
    chk("t6_count", 32'(count), 32'd0);
    chk("t6_empty", 32'(empty), 32'd1);
    chk("t6_out_valid", 32'(out_valid), 32'd0);
    chk("t6_in_ready", 32'(in_ready), 32'd1);
    cyc(1'b1, 32'hBEEF, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    drain(1, 1'b0);
    idle_chk(0);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
